// File: rtl/vcop_seq_pkg.sv
// Shared types, default parameters and the beat-count helper for the vector
// coprocessor sequencer.
package vcop_seq_pkg;

    localparam int DEF_OP_W          = 32;
    localparam int DEF_LMUL_W        = 2;
    localparam int DEF_SEW_W         = 2;
    localparam int DEF_MAX_LMUL_LOG2 = 3;
    localparam int DEF_QDEPTH        = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_WB   = 2'b10
    } state_t;

    // Number of execution beats for a register group, with lmul clamped to max_log2.
    function automatic int unsigned beat_count(input int unsigned lmul,
                                               input int unsigned max_log2);
        int unsigned sh;
        sh = (lmul > max_log2) ? max_log2 : lmul;
        return 32'd1 << sh;
    endfunction

endpackage

// File: rtl/vcop_op_fifo.sv
// Operation queue for the sequencer: synchronous FIFO, power-of-two depth,
// with occupancy count and full/empty flags.
module vcop_op_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic                     vsi_clk,
    input  logic                     vsi_rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; count decides which entries are live.
    always_ff @(posedge vsi_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
        if (!vsi_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vcop_seq_ctrl.sv
// Vector coprocessor sequencer: queues driver operations and runs each as an
// LMUL-sized multi-beat execution plus one write-back cycle. VCOP_SEQ_PERF_EN adds perf counters.
module vcop_seq_ctrl
    import vcop_seq_pkg::*;
#(
    parameter int OP_W          = DEF_OP_W,
    parameter int LMUL_W        = DEF_LMUL_W,
    parameter int SEW_W         = DEF_SEW_W,
    parameter int MAX_LMUL_LOG2 = DEF_MAX_LMUL_LOG2,
    parameter int QDEPTH        = DEF_QDEPTH
) (
    input  logic                       vsi_clk,
    input  logic                       vsi_rst_n,
    input  logic                       vsi_op_valid,
    output logic                       vsi_op_ready,
    input  logic [OP_W-1:0]            vsi_op,
    input  logic [LMUL_W-1:0]          vsi_lmul,
    input  logic [SEW_W-1:0]           vsi_sew,
    output logic                       vsi_cop_idle,
    input  logic                       dp_stall,
    output logic                       exec_en,
    output logic [MAX_LMUL_LOG2-1:0]   beat_idx,
    output logic                       last_beat,
    output logic                       write_en,
    output logic [OP_W-1:0]            op_reg,
    output logic [LMUL_W-1:0]          lmul_reg,
    output logic [SEW_W-1:0]           sew_reg,
    output logic [$clog2(QDEPTH):0]    q_count
`ifdef VCOP_SEQ_PERF_EN
    ,
    output logic [31:0]                perf_busy,
    output logic [31:0]                perf_retired
`endif
);

    localparam int FW = OP_W + LMUL_W + SEW_W;

    state_t                     state;
    state_t                     next_state;
    logic [MAX_LMUL_LOG2-1:0]   beat_cnt;
    logic [MAX_LMUL_LOG2-1:0]   last_idx;
    logic                       pop;
    logic                       q_full;
    logic                       q_empty;
    logic [FW-1:0]              q_rdata;

    assign vsi_op_ready = !q_full;
    assign vsi_cop_idle = (state == S_IDLE) && q_empty;
    assign last_idx     = MAX_LMUL_LOG2'(beat_count(32'(lmul_reg), MAX_LMUL_LOG2) - 1);

    vcop_op_fifo #(
        .W     (FW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .vsi_clk   (vsi_clk),
        .vsi_rst_n (vsi_rst_n),
        .push      (vsi_op_valid),
        .wdata     ({vsi_op, vsi_lmul, vsi_sew}),
        .pop       (pop),
        .rdata     (q_rdata),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        exec_en    = 1'b0;
        last_beat  = 1'b0;
        write_en   = 1'b0;
        beat_idx   = '0;
        case (state)
            S_IDLE: begin
                if (!q_empty) begin
                    pop        = 1'b1;
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                beat_idx  = beat_cnt;
                exec_en   = !dp_stall;
                last_beat = (beat_cnt == last_idx);
                if (!dp_stall && last_beat) next_state = S_WB;
            end
            S_WB: begin
                // Back-to-back issue: the next queued op is popped during write-back.
                write_en = 1'b1;
                if (!q_empty) begin
                    pop        = 1'b1;
                    next_state = S_EXEC;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
        if (!vsi_rst_n) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            op_reg   <= '0;
            lmul_reg <= '0;
            sew_reg  <= '0;
        end else begin
            state <= next_state;
            if (pop) begin
                {op_reg, lmul_reg, sew_reg} <= q_rdata;
                beat_cnt                    <= '0;
            end else if (state == S_EXEC && !dp_stall && !last_beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

`ifdef VCOP_SEQ_PERF_EN
    always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
        if (!vsi_rst_n) begin
            perf_busy    <= '0;
            perf_retired <= '0;
        end else begin
            if (state != S_IDLE && perf_busy != 32'hFFFF_FFFF) perf_busy <= perf_busy + 1'b1;
            if (state == S_WB && perf_retired != 32'hFFFF_FFFF) perf_retired <= perf_retired + 1'b1;
        end
    end
`else
    // Counters absent in this build.
`endif

endmodule

// File: tb/tb_vcop_seq_ctrl.sv
// Scoreboard bench for vcop_seq_ctrl: directed ops push expected write-backs,
// a negedge monitor checks beat order and retirement.
module tb_vcop_seq_ctrl;

    localparam int OP_W  = 32;
    localparam int LMW   = 3;
    localparam int SEW_W = 2;
    localparam int MAXL  = 3;
    localparam int QD    = 4;

    logic              vsi_clk      = 1'b0;
    logic              vsi_rst_n    = 1'b0;
    logic              vsi_op_valid = 1'b0;
    logic [OP_W-1:0]   vsi_op       = '0;
    logic [LMW-1:0]    vsi_lmul     = '0;
    logic [SEW_W-1:0]  vsi_sew      = '0;
    logic              dp_stall     = 1'b0;
    logic              vsi_op_ready;
    logic              vsi_cop_idle;
    logic              exec_en;
    logic [MAXL-1:0]   beat_idx;
    logic              last_beat;
    logic              write_en;
    logic [OP_W-1:0]   op_reg;
    logic [LMW-1:0]    lmul_reg;
    logic [SEW_W-1:0]  sew_reg;
    logic [2:0]        q_count;
`ifdef VCOP_SEQ_PERF_EN
    logic [31:0]       perf_busy;
    logic [31:0]       perf_retired;
`endif

    vcop_seq_ctrl #(
        .OP_W(OP_W), .LMUL_W(LMW), .SEW_W(SEW_W), .MAX_LMUL_LOG2(MAXL), .QDEPTH(QD)
    ) dut (
        .vsi_clk      (vsi_clk),
        .vsi_rst_n    (vsi_rst_n),
        .vsi_op_valid (vsi_op_valid),
        .vsi_op_ready (vsi_op_ready),
        .vsi_op       (vsi_op),
        .vsi_lmul     (vsi_lmul),
        .vsi_sew      (vsi_sew),
        .vsi_cop_idle (vsi_cop_idle),
        .dp_stall     (dp_stall),
        .exec_en      (exec_en),
        .beat_idx     (beat_idx),
        .last_beat    (last_beat),
        .write_en     (write_en),
        .op_reg       (op_reg),
        .lmul_reg     (lmul_reg),
        .sew_reg      (sew_reg),
        .q_count      (q_count)
`ifdef VCOP_SEQ_PERF_EN
        ,
        .perf_busy    (perf_busy),
        .perf_retired (perf_retired)
`endif
    );

    always #5 vsi_clk = ~vsi_clk;

    typedef struct {
        logic [OP_W-1:0]  op;
        logic [LMW-1:0]   lmul;
        logic [SEW_W-1:0] sew;
        int               beats;
    } exp_t;

    exp_t exp_q[$];
    int   wb_cyc[$];
    int   wb_beats[$];
    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;
    int   beat_seen = 0;
    bit   saw_full  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge vsi_clk);
        #1;
    endtask

    // Offer one op; the expected write-back is queued when the edge will accept it.
    task automatic push_op(input logic [OP_W-1:0] op, input logic [LMW-1:0] lmul,
                           input logic [SEW_W-1:0] sew, input int beats);
        bit accepted = 0;
        vsi_op_valid = 1'b1;
        vsi_op       = op;
        vsi_lmul     = lmul;
        vsi_sew      = sew;
        for (int i = 0; i < 50; i++) begin
            check("ready_eq_not_full", vsi_op_ready, q_count != QD);
            if (q_count == QD && !vsi_op_ready) saw_full = 1;
            if (vsi_op_ready) begin
                exp_q.push_back('{op, lmul, sew, beats});
                tick();
                accepted = 1;
                break;
            end
            tick();
        end
        if (!accepted) check("push_timeout", 0, 1);
        vsi_op_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && vsi_cop_idle) break;
            tick();
        end
        check("drain_done", (exp_q.size() == 0) && vsi_cop_idle, 1);
    endtask

    always @(posedge vsi_clk) cyc <= cyc + 1;

    always @(negedge vsi_clk) begin
        exp_t e;
        if (!vsi_rst_n) begin
            beat_seen = 0;
        end else begin
            if (exec_en) begin
                check("beat_idx_seq", beat_idx, beat_seen);
                beat_seen++;
            end
            if (write_en) begin
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_op", op_reg, e.op);
                    check("wb_lmul", lmul_reg, e.lmul);
                    check("wb_sew", sew_reg, e.sew);
                    check("wb_beats", beat_seen, e.beats);
                    wb_cyc.push_back(cyc);
                    wb_beats.push_back(e.beats);
                end
                beat_seen = 0;
            end
        end
    end

    initial begin
        int exp_b[10] = '{0, 1, 2, 2, 3, 4, 5, 5, 6, 7};
        bit exp_e[10] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1};

        // Reset state
        #12;
        check("rst_ready", vsi_op_ready, 1);
        check("rst_idle", vsi_cop_idle, 1);
        check("rst_exec_en", exec_en, 0);
        check("rst_write_en", write_en, 0);
        check("rst_beat_idx", beat_idx, 0);
        check("rst_q_count", q_count, 0);
        check("rst_op_reg", op_reg, 0);
        tick();
        vsi_rst_n = 1'b1;
        tick();

        // Single op, lmul=0: EXEC, WB, IDLE
        push_op(32'hA5A5_0001, 3'd0, 2'd1, 1);
        check("t1_q_count", q_count, 1);
        check("t1_not_idle", vsi_cop_idle, 0);
        tick();
        check("t1_exec_en", exec_en, 1);
        check("t1_beat0", beat_idx, 0);
        check("t1_last", last_beat, 1);
        tick();
        check("t1_write_en", write_en, 1);
        check("t1_no_exec_in_wb", exec_en, 0);
        tick();
        check("t1_idle", vsi_cop_idle, 1);
        check("t1_wb_one_cycle", write_en, 0);

        // lmul=3 with stalls on beats 2 and 5
        push_op(32'h0000_1234, 3'd3, 2'd2, 8);
        tick();
        for (int c = 0; c < 10; c++) begin
            dp_stall = (c == 2 || c == 6);
            #1;
            check("t2_exec_en", exec_en, exp_e[c]);
            check("t2_beat_idx", beat_idx, exp_b[c]);
            check("t2_last", last_beat, c == 9);
            tick();
        end
        dp_stall = 1'b1;
        #1;
        check("t2_wb_after_10", write_en, 1);
        tick();
        dp_stall = 1'b0;
        check("t2_wb_ignores_stall", vsi_cop_idle, 1);

        // Five ops queued behind a running one, incl. clamp of lmul=7
        wb_cyc.delete();
        wb_beats.delete();
        saw_full = 0;
        push_op(32'hB000_0000, 3'd2, 2'd0, 4);
        push_op(32'hB000_0001, 3'd0, 2'd1, 1);
        push_op(32'hB000_0002, 3'd1, 2'd2, 2);
        push_op(32'hB000_0003, 3'd2, 2'd3, 4);
        push_op(32'hB000_0004, 3'd3, 2'd0, 8);
        push_op(32'hB000_0005, 3'd7, 2'd1, 8);
        drain();
        check("t3_ready_dropped_at_full", saw_full, 1);
        check("t3_retired", wb_cyc.size(), 6);
        for (int i = 1; i < wb_cyc.size(); i++)
            check("t3_wb_gap", wb_cyc[i] - wb_cyc[i-1], wb_beats[i] + 1);

        // Reset mid-EXEC with three ops queued
        push_op(32'hC000_0000, 3'd3, 2'd1, 8);
        push_op(32'hC000_0001, 3'd1, 2'd1, 2);
        push_op(32'hC000_0002, 3'd1, 2'd1, 2);
        push_op(32'hC000_0003, 3'd1, 2'd1, 2);
        check("t4_q_count_pre", q_count, 3);
        check("t4_exec_pre", exec_en, 1);
        check("t4_beat_pre", beat_idx, 2);
        vsi_rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t4_q_count", q_count, 0);
        check("t4_exec_en", exec_en, 0);
        check("t4_beat_idx", beat_idx, 0);
        check("t4_ready", vsi_op_ready, 1);
        check("t4_idle", vsi_cop_idle, 1);
        check("t4_op_reg", op_reg, 0);
        check("t4_lmul_reg", lmul_reg, 0);
        tick();
        vsi_rst_n = 1'b1;
        tick();

        // Fresh ops after reset: three lmul=1 back-to-back
        push_op(32'hD000_0000, 3'd1, 2'd0, 2);
        push_op(32'hD000_0001, 3'd1, 2'd1, 2);
        push_op(32'hD000_0002, 3'd1, 2'd2, 2);
        drain();
`ifdef VCOP_SEQ_PERF_EN
        check("perf_retired", perf_retired, 3);
        check("perf_busy", perf_busy, 9);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
